// File: rtl/png_pkg.sv
// png_pkg: shared definitions for the PNG chunk sequencer.
//   state_e        - chunk sequencer FSM states
//   CRC_WD         - CRC word width
//   PACE_CYC       - pace counter reload value (engine beats >= 4 cycles apart)
//   PNG_IHDR/IDAT/IEND - chunk type words, first byte in [31:24]
//   png_len_word() - length field of a chunk: payload words -> byte count
package png_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_TYP,
        ST_DAT,
        ST_WAIT,
        ST_CRC
    } state_e;

    localparam int          CRC_WD   = 32;
    localparam logic [1:0]  PACE_CYC = 2'd3;

    localparam logic [31:0] PNG_IHDR = 32'h49484452;
    localparam logic [31:0] PNG_IDAT = 32'h49444154;
    localparam logic [31:0] PNG_IEND = 32'h49454E44;

    // Byte count of a payload given in 32-bit words.
    function automatic logic [31:0] png_len_word(input logic [29:0] len);
        return {len, 2'b00};
    endfunction

endpackage

// File: rtl/png_chunk_oreg.sv
// png_chunk_oreg: single-entry valid/ready output register carrying data + lst.
//   clk, rstn      clock, async active-low reset
//   ld_i           load a new entry (only asserted when free_o)
//   dat_i, lst_i   entry payload
//   rdy_i          downstream ready
//   val_o, dat_o, lst_o  registered entry
//   free_o         entry can accept a load this cycle (empty or draining)
module png_chunk_oreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ld_i,
    input  logic [W-1:0] dat_i,
    input  logic         lst_i,
    input  logic         rdy_i,
    output logic         val_o,
    output logic [W-1:0] dat_o,
    output logic         lst_o,
    output logic         free_o
);

    logic         val_q;
    logic [W-1:0] dat_q;
    logic         lst_q;

    // Loading while draining keeps full throughput.
    assign free_o = !val_q || rdy_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            val_q <= 1'b0;
            dat_q <= '0;
            lst_q <= 1'b0;
        end else if (ld_i) begin
            val_q <= 1'b1;
            dat_q <= dat_i;
            lst_q <= lst_i;
        end else if (rdy_i) begin
            val_q <= 1'b0;
            lst_q <= 1'b0;
        end
    end

    assign val_o = val_q;
    assign dat_o = dat_q;
    assign lst_o = lst_q;

endmodule

// File: rtl/png_chunk_ctrl.sv
// png_chunk_ctrl: sequences one PNG chunk (length, type, payload, CRC) onto the
// 32-bit output stream while feeding type+payload to an external crc32 engine,
// pacing engine beats at least 4 cycles apart.
//   clk, rstn                      clock, async active-low reset
//   start_i, len_i, type_i, busy_o chunk request / busy
//   in_val_i, in_rdy_o, in_dat_i, in_lst_i   payload input
//   out_val_o, out_rdy_i, out_dat_o, out_lst_o  chunk word output
//   crc_start_o, crc_val_o, crc_dat_o, crc_lst_o, crc_dat_i  engine interface
//   err_o                          sticky length mismatch flag
// Optional feature: PNG_CHUNK_CTRL_LEN_CHK_EN enables in_lst_i checking on
// err_o; when undefined in_lst_i is ignored and err_o is 0.
module png_chunk_ctrl
    import png_pkg::*;
#(
    parameter int LEN_WD = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [LEN_WD-1:0] len_i,
    input  logic [31:0]       type_i,
    output logic              busy_o,
    input  logic              in_val_i,
    output logic              in_rdy_o,
    input  logic [31:0]       in_dat_i,
    input  logic              in_lst_i,
    output logic              out_val_o,
    input  logic              out_rdy_i,
    output logic [31:0]       out_dat_o,
    output logic              out_lst_o,
    output logic              crc_start_o,
    output logic              crc_val_o,
    output logic [31:0]       crc_dat_o,
    output logic              crc_lst_o,
    input  logic [CRC_WD-1:0] crc_dat_i,
    output logic              err_o
);

    state_e            state_q;
    logic [LEN_WD-1:0] len_q;
    logic [31:0]       type_q;
    logic [LEN_WD-1:0] cnt_q;
    logic [1:0]        pace_q;
    logic              busy_q;

    logic        oreg_free;
    logic        oreg_ld;
    logic [31:0] oreg_dat_d;
    logic        oreg_lst_d;

    logic start_acc, typ_beat, dat_beat, crc_cap, in_rdy;
    logic pace_zero, len_zero, cnt_last;

    assign pace_zero = (pace_q == 2'd0);
    assign len_zero  = (len_q == '0);
    // Only meaningful in DAT, where len_q != 0.
    assign cnt_last  = (cnt_q == len_q - LEN_WD'(1));

    always_comb begin
        start_acc = (state_q == ST_IDLE) && start_i;
        // LEN holds the length word; the type beat is tried there already so
        // an unstalled chunk needs no extra cycle. TYP retries under stall.
        typ_beat  = ((state_q == ST_LEN) || (state_q == ST_TYP)) && pace_zero && oreg_free;
        in_rdy    = (state_q == ST_DAT) && pace_zero && oreg_free;
        dat_beat  = in_rdy && in_val_i;
        crc_cap   = (state_q == ST_WAIT) && pace_zero && oreg_free;

        oreg_ld    = start_acc || typ_beat || dat_beat || crc_cap;
        oreg_dat_d = '0;
        oreg_lst_d = 1'b0;
        if (start_acc) begin
            oreg_dat_d = png_len_word(30'(len_i));
        end else if (typ_beat) begin
            oreg_dat_d = type_q;
        end else if (dat_beat) begin
            oreg_dat_d = in_dat_i;
        end else if (crc_cap) begin
            oreg_dat_d = crc_dat_i;
            oreg_lst_d = 1'b1;
        end
    end

    assign crc_start_o = start_acc;
    assign crc_val_o   = typ_beat || dat_beat;
    assign crc_dat_o   = typ_beat ? type_q : (dat_beat ? in_dat_i : 32'h0);
    assign crc_lst_o   = (typ_beat && len_zero) || (dat_beat && cnt_last);
    assign in_rdy_o    = in_rdy;
    assign busy_o      = busy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            type_q  <= '0;
            cnt_q   <= '0;
            pace_q  <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            if (crc_val_o) begin
                pace_q <= PACE_CYC;
            end else if (!pace_zero) begin
                pace_q <= pace_q - 2'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q   <= len_i;
                        type_q  <= type_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN, ST_TYP: begin
                    if (typ_beat) begin
                        state_q <= len_zero ? ST_WAIT : ST_DAT;
                    end else begin
                        state_q <= ST_TYP;
                    end
                end
                ST_DAT: begin
                    if (dat_beat) begin
                        cnt_q <= cnt_q + LEN_WD'(1);
                        if (cnt_last) begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Pace at 0 means the last beat's result has settled.
                    if (crc_cap) begin
                        state_q <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (out_val_o && out_rdy_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PNG_CHUNK_CTRL_LEN_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (dat_beat && (in_lst_i != cnt_last)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_lst;
    assign unused_lst = in_lst_i;
    assign err_o      = 1'b0;
`endif

    png_chunk_oreg #(.W(32)) u_oreg (
        .clk    (clk),
        .rstn   (rstn),
        .ld_i   (oreg_ld),
        .dat_i  (oreg_dat_d),
        .lst_i  (oreg_lst_d),
        .rdy_i  (out_rdy_i),
        .val_o  (out_val_o),
        .dat_o  (out_dat_o),
        .lst_o  (out_lst_o),
        .free_o (oreg_free)
    );

endmodule

// File: tb/tb_png_chunk_ctrl.sv
module tb_png_chunk_ctrl;

    localparam logic [31:0] T_IHDR = 32'h49484452;
    localparam logic [31:0] T_IDAT = 32'h49444154;
    localparam logic [31:0] T_IEND = 32'h49454E44;
`ifdef PNG_CHUNK_CTRL_LEN_CHK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [15:0] len_i;
    logic [31:0] type_i;
    logic        busy_o;
    logic        in_val_i;
    logic        in_rdy_o;
    logic [31:0] in_dat_i;
    logic        in_lst_i;
    logic        out_val_o;
    logic        out_rdy_i;
    logic [31:0] out_dat_o;
    logic        out_lst_o;
    logic        crc_start_o;
    logic        crc_val_o;
    logic [31:0] crc_dat_o;
    logic        crc_lst_o;
    logic [31:0] crc_dat_i;
    logic        err_o;

    always #5 clk = ~clk;

    png_chunk_ctrl #(.LEN_WD(16)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .type_i(type_i),
        .busy_o(busy_o), .in_val_i(in_val_i), .in_rdy_o(in_rdy_o), .in_dat_i(in_dat_i),
        .in_lst_i(in_lst_i), .out_val_o(out_val_o), .out_rdy_i(out_rdy_i),
        .out_dat_o(out_dat_o), .out_lst_o(out_lst_o), .crc_start_o(crc_start_o),
        .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o), .crc_lst_o(crc_lst_o),
        .crc_dat_i(crc_dat_i), .err_o(err_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint got, input longint exp_v);
        n_chk++;
        if (got != exp_v) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp_v);
        end
    endtask

    // Reflected CRC-32 (zlib polynomial), one byte at a time.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Stand-in for the shared crc32 engine that sits beside the block.
    logic [31:0] eng_q;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) eng_q <= 32'hFFFFFFFF;
        else if (crc_start_o) eng_q <= 32'hFFFFFFFF;
        else if (crc_val_o)
            eng_q <= crc_byte(crc_byte(crc_byte(crc_byte(eng_q, crc_dat_o[31:24]),
                     crc_dat_o[23:16]), crc_dat_o[15:8]), crc_dat_o[7:0]);
    end
    assign crc_dat_i = ~eng_q;

    // Monitor: output handshakes, engine beats, start pulses.
    typedef struct packed {logic lst; logic [31:0] dat;} ow_t;
    ow_t got[$];
    int  bcyc[$];
    int  cyc = 0;
    int  n_start = 0, gap_bad = 0, last_beat = -100, start_cyc = 0, crcv_cyc = 0;
    bit  lst_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            last_beat <= -100;
            lst_seen  <= 1'b0;
        end else begin
            if (crc_start_o) begin
                n_start   <= n_start + 1;
                start_cyc <= cyc;
            end
            if (crc_val_o) begin
                if (cyc - last_beat < 4) gap_bad <= gap_bad + 1;
                last_beat <= cyc;
                bcyc.push_back(cyc);
            end
            if (out_val_o && out_lst_o && !lst_seen) crcv_cyc <= cyc;
            lst_seen <= out_val_o && out_lst_o;
            if (out_val_o && out_rdy_i) got.push_back({out_lst_o, out_dat_o});
        end
    end

    logic [31:0] pay[16];

    task automatic set_fixed_pay();
        pay[0] = 32'h78DA0102;
        pay[1] = 32'h03040506;
        pay[2] = 32'h0708090A;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":out_val"}, out_val_o, 0);
        chk({tag, ":out_lst"}, out_lst_o, 0);
        chk({tag, ":out_dat"}, out_dat_o, 0);
        chk({tag, ":busy"}, busy_o, 0);
        chk({tag, ":crc_start"}, crc_start_o, 0);
        chk({tag, ":crc_val"}, crc_val_o, 0);
        chk({tag, ":crc_lst"}, crc_lst_o, 0);
        chk({tag, ":crc_dat"}, crc_dat_o, 0);
        chk({tag, ":in_rdy"}, in_rdy_o, 0);
        chk({tag, ":err"}, err_o, 0);
    endtask

    // Runs one whole chunk; expected stream comes from the chunk format rules
    // and a byte-wise CRC over type + payload.
    task automatic run_chunk(input string nm, input logic [31:0] typ, input int len,
                             input int rdy_pct, input int lst_pos, input int dup_at,
                             input bit exp_err, input bit exact,
                             output logic [31:0] first_w, output logic [31:0] last_w);
        ow_t expq[$];
        byte unsigned bq[$];
        logic [31:0] c;
        int base, bbase, sbase, gbase, idx, cy;
        bit done, acc, hs, duped;

        expq.push_back({1'b0, 32'(len * 4)});
        expq.push_back({1'b0, typ});
        for (int b = 0; b < 4; b++) bq.push_back(typ[31-8*b -: 8]);
        for (int i = 0; i < len; i++) begin
            expq.push_back({1'b0, pay[i]});
            for (int b = 0; b < 4; b++) bq.push_back(pay[i][31-8*b -: 8]);
        end
        c = 32'hFFFFFFFF;
        foreach (bq[i]) c = crc_byte(c, bq[i]);
        expq.push_back({1'b1, ~c});

        base  = got.size();
        bbase = bcyc.size();
        sbase = n_start;
        gbase = gap_bad;

        out_rdy_i = 1'b1;
        in_val_i  = 1'b0;
        start_i   = 1'b1;
        len_i     = 16'(len);
        type_i    = typ;
        @(posedge clk); #1;
        start_i = 1'b0;
        len_i   = 16'($urandom);
        type_i  = $urandom;
        chk({nm, ":busy_rise"}, busy_o, 1);
        chk({nm, ":err_clr"}, err_o, 0);

        idx = 0; cy = 0; done = 1'b0; duped = 1'b0;
        while (!done && cy < 200 + len * 40) begin
            out_rdy_i = ($urandom_range(0, 99) < rdy_pct);
            in_val_i  = (idx < len);
            in_dat_i  = (idx < len) ? pay[idx] : $urandom;
            in_lst_i  = (idx == lst_pos);
            if (dup_at >= 0 && idx == dup_at && !duped) begin
                start_i = 1'b1;
                len_i   = 16'd7;
                type_i  = T_IHDR;
                duped   = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            acc = in_val_i && in_rdy_o;
            hs  = out_val_o && out_rdy_i && out_lst_o;
            @(posedge clk); #1;
            if (acc) idx++;
            if (hs) done = 1'b1;
            cy++;
        end
        start_i  = 1'b0;
        in_val_i = 1'b0;
        in_lst_i = 1'b0;

        chk({nm, ":completed"}, done, 1);
        chk({nm, ":busy_fall"}, busy_o, 0);
        chk({nm, ":nwords"}, got.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (base + i < got.size()) begin
                chk($sformatf("%s:w%0d_dat", nm, i), got[base+i].dat, expq[i].dat);
                chk($sformatf("%s:w%0d_lst", nm, i), got[base+i].lst, expq[i].lst);
            end
        end
        chk({nm, ":nbeats"}, bcyc.size() - bbase, len + 1);
        chk({nm, ":beat_gap"}, gap_bad - gbase, 0);
        chk({nm, ":nstart"}, n_start - sbase, 1);
        if (exact && bcyc.size() >= bbase + len + 1) begin
            chk({nm, ":typ_beat_cyc"}, bcyc[bbase] - start_cyc, 1);
            for (int i = 1; i <= len; i++)
                chk($sformatf("%s:gap%0d", nm, i), bcyc[bbase+i] - bcyc[bbase+i-1], 4);
        end
        chk({nm, ":err_end"}, err_o, exp_err);
        first_w = (got.size() > base) ? got[base].dat : 32'hDEADBEEF;
        last_w  = (got.size() > base) ? got[got.size()-1].dat : 32'hDEADBEEF;
    endtask

    // Starts a chunk, feeds some words, then asserts reset mid-chunk.
    task automatic abort_chunk(input string nm, input int len, input int words,
                               input logic [31:0] exp_lw);
        int idx, cy;
        bit acc;
        out_rdy_i = 1'b1;
        start_i   = 1'b1;
        len_i     = 16'(len);
        type_i    = T_IDAT;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk({nm, ":lw_val"}, out_val_o, 1);
        chk({nm, ":lw_dat"}, out_dat_o, exp_lw);
        idx = 0; cy = 0;
        while (idx < words && cy < 200) begin
            in_val_i = 1'b1;
            in_dat_i = pay[idx];
            in_lst_i = 1'b0;
            @(negedge clk);
            acc = in_val_i && in_rdy_o;
            @(posedge clk); #1;
            if (acc) idx++;
            cy++;
        end
        chk({nm, ":accepted"}, idx, words);
        in_val_i = 1'b0;
        rstn = 1'b0;
        #1;
        chk_zero({nm, ":rst"});
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] typ;
        int          len;
        int          rdy;
        bit          fixed;
        logic [31:0] exp_lw;
        logic [31:0] exp_crc;
        bit          lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] fw, lw;
        logic [31:0] typs[4];

        tbl[0] = '{T_IEND, 0, 100, 1'b0, 32'h00000000, 32'hAE426082, 1'b1};
        tbl[1] = '{T_IDAT, 3, 100, 1'b1, 32'h0000000C, 32'h0, 1'b0};
        tbl[2] = '{T_IDAT, 3, 30,  1'b1, 32'h0000000C, 32'h0, 1'b0};
        tbl[3] = '{T_IHDR, 1, 60,  1'b0, 32'h00000004, 32'h0, 1'b0};
        tbl[4] = '{T_IDAT, 5, 100, 1'b0, 32'h00000014, 32'h0, 1'b0};

        rstn = 1'b0; start_i = 1'b0; len_i = '0; type_i = '0;
        in_val_i = 1'b0; in_dat_i = '0; in_lst_i = 1'b0; out_rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            if (tbl[t].fixed) set_fixed_pay();
            else for (int k = 0; k < 16; k++) pay[k] = $urandom;
            run_chunk($sformatf("vec%0d", t), tbl[t].typ, tbl[t].len, tbl[t].rdy,
                      tbl[t].len - 1, -1, 1'b0, tbl[t].rdy == 100, fw, lw);
            chk($sformatf("vec%0d:len_word", t), fw, tbl[t].exp_lw);
            if (tbl[t].exp_crc != 32'h0)
                chk($sformatf("vec%0d:crc_const", t), lw, tbl[t].exp_crc);
            if (tbl[t].lat)
                chk($sformatf("vec%0d:latency", t), crcv_cyc - start_cyc, 6);
        end

        // start_i during DAT is ignored.
        set_fixed_pay();
        run_chunk("dupstart", T_IDAT, 3, 100, 2, 1, 1'b0, 1'b1, fw, lw);

        // Wrong in_lst_i placement; chunk still follows len, next start clears err.
        pay[0] = 32'h11223344; pay[1] = 32'h55667788;
        run_chunk("badlst", T_IDAT, 2, 100, 0, -1, LEN_CHK, 1'b1, fw, lw);
        run_chunk("after_badlst", T_IEND, 0, 100, -1, -1, 1'b0, 1'b1, fw, lw);

        // Max length word, then mid-chunk resets and a clean IEND afterwards.
        set_fixed_pay();
        abort_chunk("maxlen", 16'hFFFF, 2, 32'h0003FFFC);
        abort_chunk("abort", 3, 1, 32'h0000000C);
        run_chunk("post_rst_iend", T_IEND, 0, 100, -1, -1, 1'b0, 1'b1, fw, lw);
        chk("post_rst_iend:crc_const", lw, 32'hAE426082);

        // Randomized chunks against the format model.
        typs[0] = T_IHDR; typs[1] = T_IDAT; typs[2] = T_IEND; typs[3] = $urandom;
        for (int r = 0; r < 10; r++) begin
            int rl, rp;
            rl = $urandom_range(0, 8);
            rp = (r % 3 == 0) ? 100 : $urandom_range(25, 90);
            for (int k = 0; k < 16; k++) pay[k] = $urandom;
            run_chunk($sformatf("rnd%0d", r), typs[$urandom_range(0, 3)], rl, rp,
                      rl - 1, -1, 1'b0, rp == 100, fw, lw);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/png_chunk_ctrl.md
# png_chunk_ctrl

Sequences one PNG chunk at a time through the shared word-serial crc32 engine and onto the 32-bit PNG output stream. The block emits four fields in order: the length word, the type word, the payload words and the CRC word. It drives the engine's start/val/lst inputs itself and paces payload so that no more than one word enters the engine every 4 cycles. It sits between the chunk producers (IHDR/IDAT/IEND formatters) and the byte-stream packer.

## Interface
- LEN_WD, 16, width of the payload length in 32-bit words
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  chunk request; sampled only in IDLE
- len_i  in  LEN_WD  payload length in words; sampled with start_i
- type_i  in  32  chunk type, first byte in [31:24]; sampled with start_i
- busy_o  out  1  high from the cycle after an accepted start_i until the CRC word handshakes
- in_val_i  in  1  payload word valid
- in_rdy_o  out  1  payload word accepted when in_val_i && in_rdy_o
- in_dat_i  in  32  payload word, first byte in [31:24]
- in_lst_i  in  1  producer marks last payload word (see Configuration)
- out_val_o  out  1  output word valid
- out_rdy_i  in  1  downstream ready
- out_dat_o  out  32  output word
- out_lst_o  out  1  high with the CRC word
- crc_start_o  out  1  engine start pulse
- crc_val_o  out  1  engine data valid
- crc_dat_o  out  32  engine data
- crc_lst_o  out  1  engine last word
- crc_dat_i  in  32  final CRC from the engine
- err_o  out  1  sticky length-mismatch flag

## Operation
- State machine states: IDLE, LEN, TYP, DAT, WAIT, CRC.
- **IDLE**
  - On start_i: latch len_i and type_i, clear the word counter, pulse crc_start_o for 1 cycle, go to LEN.
  - start_i in any other state is ignored.
- **LEN**
  - Load the output register with {len,2'b00} in the low LEN_WD+2 bits, zero-extended to 32 bits.
  - The length word is not fed to the engine.
  - Go to TYP.
- **TYP**
  - When the pace counter is 0 and the output register is free: load type into the output register, and pulse crc_val_o with crc_dat_o = type.
  - crc_lst_o = (len==0).
  - Next state is DAT if len!=0, otherwise WAIT.
- **DAT**
  - in_rdy_o = pace==0 && output register free.
  - Each accepted word goes to the output register and to the engine (crc_val_o) in the same cycle, and increments the counter.
  - crc_lst_o is asserted on word len-1; after that word, go to WAIT.
- **WAIT**
  - Hold until the pace counter reaches 0.
  - Go to CRC with crc_dat_i captured into the output register, out_lst_o = 1.
- **CRC**
  - On the out handshake, go to IDLE and drop busy_o.
- **Pacing**
  - Every crc_val_o loads the pace counter with 3; it decrements to 0.
  - A new engine beat is allowed only when the counter is 0.
- **Output register**
  - Single entry. It is free when !out_val_o || out_rdy_i.
  - It loads the same cycle it drains, giving full throughput when unpaced.
- Reset values: state IDLE; out_val_o, out_lst_o, busy_o, crc_* strobes and err_o are 0; out_dat_o and crc_dat_o are 0.
- Asynchronous reset mid-chunk abandons the chunk. The engine is re-armed by the next crc_start_o.

## Timing
- start_i at cycle S: crc_start_o is high in S (combinational from IDLE && start_i); the length word is valid from S+1.
- Engine beats are ≥4 cycles apart.
- Last beat at cycle T: the engine result is stable from T+4, and the CRC word is valid on out_dat_o from T+5.
- Minimum chunk latency from start_i to the CRC word (len=0, out_rdy_i=1): 6 cycles.
- Payload throughput: 1 word per 4 cycles. Output backpressure stalls in_rdy_o but never drops or duplicates an engine beat.
- len=2^LEN_WD−1 must not wrap the counter; the counter is LEN_WD bits wide and compared for equality.

## Configuration
- PNG_CHUNK_CTRL_LEN_CHK_EN defined:
  - err_o is set if in_lst_i is high on a word other than len-1, or low on word len-1.
  - The chunk still completes using the len count.
  - err_o is cleared by an accepted start_i.
- Undefined: in_lst_i is ignored and err_o is tied to 0.

## Structure
- Shared png_pkg holds:
  - state enum
  - CRC_WD=32
  - pace constant 3
  - chunk type constants IHDR=32'h49484452, IDAT=32'h49444154, IEND=32'h49454E44
- The crc32 engine is instantiated beside this block, not inside it.
- One natural sub-module: png_chunk_oreg, a single-entry valid/ready output register carrying data and lst.

## Test plan
- IEND, len=0, out_rdy_i=1 → output 32'h00000000, 32'h49454E44, then 32'hAE426082 with out_lst_o=1; busy_o falls after the CRC handshake.
- IDAT, len=3, payload 32'h78DA0102, 32'h03040506, 32'h0708090A → length 32'h0000000C; engine beats exactly 4 cycles apart; CRC matches the software zlib crc32 of "IDAT"+payload.
- Same IDAT with out_rdy_i random at 30% → identical output sequence; crc_val_o count = 4; no beat closer than 4 cycles.
- start_i pulsed during DAT → ignored; chunk output unchanged; no extra crc_start_o.
- rstn asserted in DAT after 1 word → all outputs 0 immediately; a following IEND chunk gives 32'hAE426082.
- With PNG_CHUNK_CTRL_LEN_CHK_EN, len=2 and in_lst_i on word 0 → err_o=1 after that beat; chunk completes with 2 words; the next start_i clears err_o.
